// File: rtl/axis_requant_lrelu_seq_pkg.sv
// Shared definitions for the requantise + leaky-ReLU stream engine:
// FSM state encoding, sticky error bit positions and pipeline latency.
package axis_requant_lrelu_seq_pkg;

    typedef enum logic [1:0] {
        CFG_HDR = 2'd0,
        CFG_MUL = 2'd1,
        PASS    = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int ERR_KW  = 0;   // header kw count out of range
    localparam int ERR_COL = 1;   // data column index out of range

    localparam int LATENCY_REQUANT = 3;

    // Width of an index into n banks (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_requant_lrelu_seq_requant_lane.sv
// Single-lane requantiser: S1 multiply, S2 arithmetic right shift,
// S3 leaky-ReLU plus saturation into the output register.
// Optional macro REQUANT_ROUND_EN: S2 rounds half up instead of flooring.
module axis_requant_lrelu_seq_requant_lane #(
    parameter int W_IN        = 32,
    parameter int W_OUT       = 8,
    parameter int MUL_W       = 16,
    parameter int SHIFT_W     = 5,
    parameter int ALPHA_SHIFT = 3
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     adv,
    input  logic signed [W_IN-1:0]   x,
    input  logic signed [MUL_W-1:0]  mul,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [W_OUT-1:0]  y
);

    localparam int PW = W_IN + MUL_W;
    localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (W_OUT - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] prod_q;
    logic signed [PW-1:0] shr_in;
    logic signed [PW-1:0] shr_d;
    logic signed [PW-1:0] shr_q;
    logic signed [PW-1:0] lrelu;
    logic signed [W_OUT-1:0] y_d;

    // S1: full-precision signed product.
    always_comb begin
        prod_d = PW'(x) * PW'(mul);
    end

    // S2: optional round-half-up bias, then arithmetic right shift.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        shr_in = prod_q;
`ifdef REQUANT_ROUND_EN
        if (shift != '0) begin
            shr_in = prod_q + (PW'(1) <<< (shift - SHIFT_W'(1)));
        end
`endif
        shr_d = shr_in >>> shift;
    end

    // S3: leaky-ReLU on negatives, then clamp to the signed output range.
    always_comb begin
        lrelu = shr_q[PW-1] ? (shr_q >>> ALPHA_SHIFT) : shr_q;
        y_d   = lrelu[W_OUT-1:0];
        if (lrelu > SAT_MAX) begin
            y_d = SAT_MAX[W_OUT-1:0];
        end else if (lrelu < SAT_MIN) begin
            y_d = SAT_MIN[W_OUT-1:0];
        end
    end

    // Stage registers; the whole lane stalls together when adv is low.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: registers use non-blocking assignments so all stages sample pre-edge values.
            prod_q <= '0;
            shr_q  <= '0;
            y      <= '0;
        end else if (adv) begin
            prod_q <= prod_d;
            shr_q  <= shr_d;
            y      <= y_d;
        end
    end

endmodule

// File: rtl/axis_requant_lrelu_seq.sv
// AXI-Stream requantise + leaky-ReLU engine. One slave stream carries an
// in-band config packet (header with per-lane shifts, then one multiplier
// beat per kernel column) followed by a data block terminated by tlast.
// Data runs through a stallable 3-stage pipeline of LANES lanes.
// Optional macro REQUANT_ROUND_EN: round half up in the shift stage.
module axis_requant_lrelu_seq
    import axis_requant_lrelu_seq_pkg::*;
#(
    parameter int LANES       = 8,
    parameter int W_IN        = 32,
    parameter int W_OUT       = 8,
    parameter int MUL_W       = 16,
    parameter int SHIFT_W     = 5,
    parameter int KW_MAX      = 3,
    parameter int ALPHA_SHIFT = 3,
    parameter int KW_BITS     = $clog2(KW_MAX + 1)
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [LANES*W_IN-1:0]    s_axis_tdata,
    input  logic [KW_BITS-1:0]       s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [LANES*W_OUT-1:0]   m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic [1:0]               err_sticky,
    output logic [1:0]               debug_state
);

    localparam int IDX_W = idx_width(KW_MAX);
    localparam logic [KW_BITS-1:0] KW_MAX_V = KW_BITS'(KW_MAX);
    localparam logic [KW_BITS-1:0] KW_ONE   = KW_BITS'(1);

    state_t state;
    state_t state_nxt;

    logic ready_int;
    logic adv;
    logic hs;

    logic        [SHIFT_W-1:0] shift_bank [LANES];
    logic signed [MUL_W-1:0]   mul_bank   [KW_MAX][LANES];
    logic        [KW_BITS-1:0] kw;
    logic        [KW_BITS-1:0] cnt;
    logic        [1:0]         err;

    logic [KW_BITS-1:0] hdr_kw;
    logic               hdr_err;
    logic [KW_BITS-1:0] bank_sel;
    logic               col_err;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;

    logic v1, v2, v3;
    logic l1, l2, l3;

    // The whole pipeline moves only when the output register can accept.
    assign adv = !v3 || m_axis_tready;

    // Ready is held low while reset is asserted; the handshake follows it.
    assign s_axis_tready = ready_int && aresetn;
    assign hs            = s_axis_tvalid && s_axis_tready;

    // Slave ready per state: config always accepted, data only when the pipe advances.
    always_comb begin
        ready_int = 1'b0;
        case (state)
            CFG_HDR, CFG_MUL: ready_int = 1'b1;
            PASS:             ready_int = adv;
            default:          ready_int = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= CFG_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: header, multiplier beats, data block, drain to empty.
    always_comb begin
        state_nxt = state;
        case (state)
            CFG_HDR: if (hs) state_nxt = CFG_MUL;
            CFG_MUL: if (hs && (cnt == '0)) state_nxt = PASS;
            PASS:    if (hs && s_axis_tlast) state_nxt = DRAIN;
            DRAIN:   if (!v1 && !v2 && (!v3 || m_axis_tready)) state_nxt = CFG_HDR;
            default: state_nxt = CFG_HDR;
        endcase
    end

    // Header kw clamp, multiplier write index and data column bank select.
    always_comb begin
        hdr_kw  = s_axis_tuser;
        hdr_err = 1'b0;
        if (s_axis_tuser == '0) begin
            hdr_kw = KW_ONE;
        end else if (s_axis_tuser > KW_MAX_V) begin
            hdr_kw  = KW_MAX_V;
            hdr_err = 1'b1;
        end

        wr_idx = IDX_W'(kw - KW_ONE - cnt);

        bank_sel = s_axis_tuser;
        col_err  = 1'b0;
        if (s_axis_tuser >= kw) begin
            bank_sel = kw - KW_ONE;
            col_err  = 1'b1;
        end
        rd_idx = IDX_W'(bank_sel);
    end

    // Config banks and sticky errors; banks only change while the pipe is empty.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: the config banks are cleared on reset because a stale shift/multiplier must never leak into a new stream.
            for (int l = 0; l < LANES; l++) begin
                shift_bank[l] <= '0;
            end
            for (int b = 0; b < KW_MAX; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    mul_bank[b][l] <= '0;
                end
            end
            kw  <= KW_ONE;
            cnt <= '0;
            err <= '0;
        end else begin
            if (state == CFG_HDR && hs) begin
                for (int l = 0; l < LANES; l++) begin
                    shift_bank[l] <= s_axis_tdata[l*W_IN +: SHIFT_W];
                end
                kw  <= hdr_kw;
                cnt <= hdr_kw - KW_ONE;
                if (hdr_err) err[ERR_KW] <= 1'b1;
            end
            if (state == CFG_MUL && hs) begin
                for (int l = 0; l < LANES; l++) begin
                    mul_bank[wr_idx][l] <= s_axis_tdata[l*W_IN +: MUL_W];
                end
                if (cnt != '0) cnt <= cnt - KW_ONE;
            end
            if (state == PASS && hs && col_err) begin
                err[ERR_COL] <= 1'b1;
            end
        end
    end

    // Valid and tlast shift chain, in lockstep with the lane stages.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            l1 <= 1'b0;
            l2 <= 1'b0;
            l3 <= 1'b0;
        end else if (adv) begin
            v1 <= hs && (state == PASS);
            l1 <= hs && (state == PASS) && s_axis_tlast;
            v2 <= v1;
            l2 <= l1;
            v3 <= v2;
            l3 <= l2;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        axis_requant_lrelu_seq_requant_lane #(
            .W_IN        (W_IN),
            .W_OUT       (W_OUT),
            .MUL_W       (MUL_W),
            .SHIFT_W     (SHIFT_W),
            .ALPHA_SHIFT (ALPHA_SHIFT)
        ) u_lane (
            .aclk    (aclk),
            .aresetn (aresetn),
            .adv     (adv),
            .x       (s_axis_tdata[l*W_IN +: W_IN]),
            .mul     (mul_bank[rd_idx][l]),
            .shift   (shift_bank[l]),
            .y       (m_axis_tdata[l*W_OUT +: W_OUT])
        );
    end

    assign m_axis_tvalid = v3;
    assign m_axis_tlast  = l3;
    assign err_sticky    = err;
    assign debug_state   = state;

endmodule

// File: tb/tb_axis_requant_lrelu_seq.sv
// Scoreboard bench for axis_requant_lrelu_seq. The driver pushes the
// expected output of every data beat at its handshake; an independent
// monitor pops and compares on each output handshake. The header field
// is widened to 3 bits so an out-of-range kw count can be expressed.
module tb_axis_requant_lrelu_seq;
    import axis_requant_lrelu_seq_pkg::*;

    localparam int LANES       = 8;
    localparam int W_IN        = 32;
    localparam int W_OUT       = 8;
    localparam int MUL_W       = 16;
    localparam int SHIFT_W     = 5;
    localparam int KW_MAX      = 3;
    localparam int ALPHA_SHIFT = 3;
    localparam int KW_BITS     = 3;

    logic                   aclk;
    logic                   aresetn;
    logic                   s_axis_tvalid;
    logic                   s_axis_tready;
    logic [LANES*W_IN-1:0]  s_axis_tdata;
    logic [KW_BITS-1:0]     s_axis_tuser;
    logic                   s_axis_tlast;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic [LANES*W_OUT-1:0] m_axis_tdata;
    logic                   m_axis_tlast;
    logic [1:0]             err_sticky;
    logic [1:0]             debug_state;

    axis_requant_lrelu_seq #(
        .LANES(LANES), .W_IN(W_IN), .W_OUT(W_OUT), .MUL_W(MUL_W),
        .SHIFT_W(SHIFT_W), .KW_MAX(KW_MAX), .ALPHA_SHIFT(ALPHA_SHIFT),
        .KW_BITS(KW_BITS)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .err_sticky(err_sticky), .debug_state(debug_state)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [LANES*W_OUT-1:0] data;
        logic                   last;
        int                     cyc;
        bit                     lat_chk;
    } exp_t;

    exp_t sb[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Bench copy of the configuration it has sent.
    int     tb_shift [LANES];
    longint tb_mul   [KW_MAX][LANES];
    longint tb_x     [LANES];
    int     tb_kw;
    logic [1:0] exp_err;

    bit rdy_rand  = 0;
    bit stall_req = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Floor division for a positive divisor.
    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    // Reference: multiply, divide by 2^shift (floor or round half up),
    // scale negatives by 1/2^ALPHA_SHIFT (floor), clamp to the output range.
    function automatic logic [W_OUT-1:0] ref_lane(input longint x, input longint m, input int s);
        longint p, d, q, hi, lo;
        p  = x * m;
        d  = longint'(1) << s;
`ifdef REQUANT_ROUND_EN
        if (s > 0) p = p + d / 2;
`endif
        q  = floor_div(p, d);
        if (q < 0) q = floor_div(q, longint'(1) << ALPHA_SHIFT);
        hi = (longint'(1) << (W_OUT - 1)) - 1;
        lo = -(longint'(1) << (W_OUT - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return W_OUT'(q);
    endfunction

    function automatic longint rand_x(input int bits);
        longint r;
        if (bits >= 32) return longint'(int'($urandom));
        r = longint'($urandom_range((1 << bits) - 1));
        return r - (longint'(1) << (bits - 1));
    endfunction

    // Output ready: all-ones, random, or forced low on request.
    always @(posedge aclk) begin
        #1;
        if (stall_req)     m_axis_tready = 1'b0;
        else if (rdy_rand) m_axis_tready = ($urandom_range(3) != 0);
        else               m_axis_tready = 1'b1;
    end

    // Monitor: compare on output handshakes, check AXIS hold behaviour.
    initial begin
        bit hold_pend;
        logic [LANES*W_OUT-1:0] hold_data;
        logic hold_last;
        exp_t e;
        hold_pend = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                hold_pend = 0;
            end else begin
                if (hold_pend) begin
                    check("tvalid_held", 64'(m_axis_tvalid), 64'd1);
                    check("tdata_stable", 64'(m_axis_tdata), 64'(hold_data));
                    check("tlast_stable", 64'(m_axis_tlast), 64'(hold_last));
                end
                if (m_axis_tvalid && !m_axis_tready) begin
                    check("s_ready_while_stalled", 64'(s_axis_tready), 64'd0);
                    hold_pend = 1;
                    hold_data = m_axis_tdata;
                    hold_last = m_axis_tlast;
                end else begin
                    hold_pend = 0;
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (sb.size() == 0) begin
                        check("output_without_expect", 64'(sb.size()), 64'd1);
                    end else begin
                        e = sb.pop_front();
                        check("tdata", 64'(m_axis_tdata), 64'(e.data));
                        check("tlast", 64'(m_axis_tlast), 64'(e.last));
                        if (e.lat_chk) check("latency", 64'(cyc - e.cyc), 64'(LATENCY_REQUANT));
                    end
                end
            end
        end
    end

    // Present one beat and wait (bounded) for its handshake.
    task automatic send_beat(input logic [LANES*W_IN-1:0] d, input logic [KW_BITS-1:0] u,
                             input logic l, input bit is_data, input exp_t e);
        bit got;
        got = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                got = 1;
                break;
            end
        end
        if (!got) check("s_ready_timeout", 64'(got), 64'd1);
        else if (is_data) begin
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_config(input logic [KW_BITS-1:0] u, input bit chk_empty);
        logic [LANES*W_IN-1:0] d;
        logic [W_IN-1:0] w;
        exp_t dummy;
        dummy.data = '0; dummy.last = 0; dummy.cyc = 0; dummy.lat_chk = 0;
        if (u == 0) tb_kw = 1;
        else if (int'(u) > KW_MAX) begin
            tb_kw = KW_MAX;
            exp_err[ERR_KW] = 1'b1;
        end else tb_kw = int'(u);
        for (int l = 0; l < LANES; l++) begin
            w = $urandom;
            w[SHIFT_W-1:0] = SHIFT_W'(tb_shift[l]);
            d[l*W_IN +: W_IN] = w;
        end
        send_beat(d, u, 1'($urandom), 0, dummy);
        if (chk_empty) check("drained_before_header", 64'(sb.size()), 64'd0);
        for (int b = 0; b < tb_kw; b++) begin
            for (int l = 0; l < LANES; l++) begin
                w = $urandom;
                w[MUL_W-1:0] = MUL_W'(tb_mul[b][l]);
                d[l*W_IN +: W_IN] = w;
            end
            send_beat(d, KW_BITS'($urandom), 1'($urandom), 0, dummy);
        end
    endtask

    task automatic send_data(input int col, input logic last, input bit lat_chk);
        logic [LANES*W_IN-1:0] d;
        exp_t e;
        int bank;
        bank = (col >= tb_kw) ? tb_kw - 1 : col;
        if (col >= tb_kw) exp_err[ERR_COL] = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            d[l*W_IN +: W_IN] = tb_x[l][W_IN-1:0];
            e.data[l*W_OUT +: W_OUT] = ref_lane(tb_x[l], tb_mul[bank][l], tb_shift[l]);
        end
        e.last    = last;
        e.cyc     = 0;
        e.lat_chk = lat_chk;
        send_beat(d, KW_BITS'(col), last, 1, e);
    endtask

    task automatic random_cfg();
        for (int l = 0; l < LANES; l++) begin
            tb_shift[l] = $urandom_range((1 << SHIFT_W) - 1);
            for (int b = 0; b < KW_MAX; b++) tb_mul[b][l] = longint'(shortint'($urandom));
        end
    endtask

    task automatic random_x();
        int k;
        k = $urandom_range(2);
        for (int l = 0; l < LANES; l++) tb_x[l] = rand_x(k == 0 ? 12 : (k == 1 ? 24 : 32));
    endtask

    // Wait (bounded) for the scoreboard to empty and the FSM to return to the header state.
    task automatic wait_drain();
        for (int i = 0; i < 500; i++) begin
            @(negedge aclk);
            if (sb.size() == 0 && debug_state == 2'(CFG_HDR)) break;
        end
        check("idle_after_block", 64'(debug_state), 64'(CFG_HDR));
        check("sb_empty_after_block", 64'(sb.size()), 64'd0);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int n;
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        exp_err       = 2'b00;

        // Reset state.
        repeat (3) @(posedge aclk);
        #1;
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_err", 64'(err_sticky), 64'd0);
        check("rst_state", 64'(debug_state), 64'(CFG_HDR));
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("s_ready_after_reset", 64'(s_axis_tready), 64'd1);
        @(posedge aclk);
        #1;

        // Basic: shift 4, multipliers 3 and -5, x = 160 -> 30 and -7.
        for (int l = 0; l < LANES; l++) begin
            tb_shift[l] = 4; tb_mul[0][l] = 3; tb_mul[1][l] = -5; tb_mul[2][l] = 0;
            tb_x[l] = 160;
        end
        send_config(KW_BITS'(2), 0);
        send_data(0, 1'b0, 1);
        send_data(1, 1'b1, 1);
        wait_drain();

        // Saturation: shift 0, mul 1000.
        for (int l = 0; l < LANES; l++) begin
            tb_shift[l] = 0; tb_mul[0][l] = 1000;
            tb_x[l] = (l % 2 == 0) ? 1000 : -1000000;
        end
        send_config(KW_BITS'(1), 0);
        send_data(0, 1'b0, 1);
        for (int l = 0; l < LANES; l++) tb_x[l] = (l % 2 == 0) ? -1000000 : 1000;
        send_data(0, 1'b1, 1);
        wait_drain();

        // Random blocks under random output backpressure.
        rdy_rand = 1;
        for (int blk = 0; blk < 4; blk++) begin
            random_cfg();
            send_config(KW_BITS'($urandom_range(KW_MAX)), 0);
            n = $urandom_range(12, 6);
            for (int i = 0; i < n; i++) begin
                random_x();
                send_data($urandom_range(tb_kw - 1), 1'(i == n - 1), 0);
            end
            wait_drain();
        end

        // Five-cycle hold of m_axis_tready mid-block.
        rdy_rand = 0;
        random_cfg();
        send_config(KW_BITS'(3), 0);
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    random_x();
                    send_data($urandom_range(tb_kw - 1), 1'(i == 9), 0);
                end
            end
            begin
                repeat (3) @(negedge aclk);
                stall_req = 1;
                repeat (5) @(negedge aclk);
                stall_req = 0;
            end
        join
        wait_drain();

        // Block boundary: tlast on beat 4, new header only after the drain.
        rdy_rand = 1;
        random_cfg();
        send_config(KW_BITS'(2), 0);
        for (int i = 0; i < 4; i++) begin
            random_x();
            send_data($urandom_range(tb_kw - 1), 1'(i == 3), 0);
        end
        check("drain_state", 64'(debug_state), 64'(DRAIN));
        check("drain_s_ready", 64'(s_axis_tready), 64'd0);
        random_cfg();
        send_config(KW_BITS'(1), 1);
        for (int i = 0; i < 3; i++) begin
            random_x();
            send_data(0, 1'(i == 2), 0);
        end
        wait_drain();

        // Range errors: kw 7 clamps to 3; column 3 uses bank 2.
        rdy_rand = 0;
        random_cfg();
        send_config(KW_BITS'(7), 0);
        check("err_after_bad_kw", 64'(err_sticky), 64'(exp_err));
        random_x();
        send_data(1, 1'b0, 0);
        random_x();
        send_data(3, 1'b0, 0);
        check("err_after_bad_col", 64'(err_sticky), 64'(exp_err));
        random_x();
        send_data(2, 1'b1, 0);
        wait_drain();
        check("err_sticky_holds", 64'(err_sticky), 64'(exp_err));

        // Asynchronous reset with two beats in flight.
        random_cfg();
        for (int l = 0; l < LANES; l++) begin
            tb_shift[0] = 3;
            tb_mul[0][l] = 7;
        end
        send_config(KW_BITS'(1), 0);
        random_x();
        send_data(0, 1'b0, 0);
        random_x();
        send_data(0, 1'b0, 0);
        #1;
        sb.delete();
        aresetn = 1'b0;
        exp_err = 2'b00;
        #1;
        check("mid_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_state", 64'(debug_state), 64'(CFG_HDR));
        check("mid_rst_err", 64'(err_sticky), 64'd0);
        check("mid_rst_s_ready", 64'(s_axis_tready), 64'd0);
        check("mid_rst_mul_bank", 64'(dut.mul_bank[0][0]), 64'd0);
        check("mid_rst_shift_bank", 64'(dut.shift_bank[0]), 64'd0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (6) @(posedge aclk);
        #1;
        check("post_rst_state", 64'(debug_state), 64'(CFG_HDR));

        // A clean block after reset.
        random_cfg();
        send_config(KW_BITS'(2), 0);
        for (int i = 0; i < 3; i++) begin
            random_x();
            send_data($urandom_range(1), 1'(i == 2), 0);
        end
        wait_drain();
        check("final_err", 64'(err_sticky), 64'(exp_err));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
